// File: rtl/wb_pkg.sv
// wb_pkg: shared load-size encodings, writeback entry type and count-width helper
// for the buffered writeback stage.
package wb_pkg;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    localparam int N_DEF      = 32;
    localparam int REG_AW_DEF = 4;

    // Entry layout at the default widths; the stage declares the same shape at its own widths.
    typedef struct packed {
        logic [REG_AW_DEF-1:0] dest;
        logic [N_DEF-1:0]      value;
    } wb_entry_t;

    // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_stage_buffered_load_extract.sv
// load_extract: picks the ALU result or load data and applies byte/halfword
// extraction with zero or sign extension.
module load_extract
    import wb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] alu_res,
    input  logic [N-1:0] mem_data,
    input  logic         mem_r_en,
    input  logic [1:0]   ld_size,
    input  logic         ld_signed,
    input  logic [1:0]   addr_lo,
    output logic [N-1:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = 8'(mem_data[31:0] >> {addr_lo, 3'b000});
    // Halfword lanes are selected by addr_lo[1] only; addr_lo[0] has no effect.
    assign h = 16'(mem_data[31:0] >> {addr_lo[1], 4'b0000});

    always_comb begin
        value = !mem_r_en          ? alu_res :
                ld_size == LD_BYTE ? {{(N-8){ld_signed & b[7]}}, b} :
                ld_size == LD_HALF ? {{(N-16){ld_signed & h[15]}}, h} :
                                     mem_data;
    end

endmodule

// File: rtl/wb_stage_buffered.sv
// wb_stage_buffered: writeback stage that queues completed writes in a DEPTH-entry FIFO
// for an externally granted register-file port and reports pending-write hazards.
module wb_stage_buffered
    import wb_pkg::*;
#(
    parameter int N      = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             alu_res,
    input  logic [N-1:0]             mem_data,
    input  logic                     mem_r_en,
    input  logic                     wb_en_in,
    input  logic [REG_AW-1:0]        wb_dest_in,
    input  logic [1:0]               ld_size,
    input  logic                     ld_signed,
    input  logic [1:0]               addr_lo,
    input  logic                     rf_grant,
    output logic                     wb_en_out,
    output logic [REG_AW-1:0]        wb_dest_out,
    output logic [N-1:0]             wb_value_out,
    input  logic [REG_AW-1:0]        hz_src1,
    input  logic [REG_AW-1:0]        hz_src2,
    output logic                     hz1,
    output logic                     hz2,
    output logic [N-1:0]             fwd1,
    output logic [N-1:0]             fwd2,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [N-1:0]      value;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [N-1:0]    in_value;
    logic            empty;
    logic            push;
    logic            pop;

    load_extract #(.N(N)) u_extract (
        .alu_res   (alu_res),
        .mem_data  (mem_data),
        .mem_r_en  (mem_r_en),
        .ld_size   (ld_size),
        .ld_signed (ld_signed),
        .addr_lo   (addr_lo),
        .value     (in_value)
    );

    // in_ready depends only on registered occupancy, so rf_grant never reaches it.
    assign empty        = (count_q == '0);
    assign in_ready     = rst & (count_q != CW'(DEPTH));
    assign push         = in_valid & in_ready & wb_en_in;
    assign pop          = ~empty & rf_grant;
    assign wb_en_out    = pop;
    assign wb_dest_out  = empty ? '0 : mem_q[rd_ptr].dest;
    assign wb_value_out = empty ? '0 : mem_q[rd_ptr].value;
    assign count        = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= '{dest: wb_dest_in, value: in_value};
    end

    // Scan oldest to youngest so later matches win; the accepting beat is youngest of all.
    always_comb begin
        hz1  = 1'b0;
        hz2  = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[rd_ptr + AW'(i)] && mem_q[rd_ptr + AW'(i)].dest == hz_src1) begin
                hz1  = 1'b1;
                fwd1 = mem_q[rd_ptr + AW'(i)].value;
            end
            if (vld_q[rd_ptr + AW'(i)] && mem_q[rd_ptr + AW'(i)].dest == hz_src2) begin
                hz2  = 1'b1;
                fwd2 = mem_q[rd_ptr + AW'(i)].value;
            end
        end
        if (push && wb_dest_in == hz_src1) begin
            hz1  = 1'b1;
            fwd1 = in_value;
        end
        if (push && wb_dest_in == hz_src2) begin
            hz2  = 1'b1;
            fwd2 = in_value;
        end
    end

endmodule

// File: tb/tb_wb_stage_buffered.sv
// tb_wb_stage_buffered: directed and randomized checks of the buffered writeback stage
// against a queue-based reference model.
module tb_wb_stage_buffered;

    localparam int N     = 32;
    localparam int RAW   = 4;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, mem_r_en, wb_en_in, ld_signed, rf_grant;
    logic [N-1:0]   alu_res, mem_data, wb_value_out, fwd1, fwd2;
    logic [RAW-1:0] wb_dest_in, wb_dest_out, hz_src1, hz_src2;
    logic [1:0]     ld_size, addr_lo;
    logic           wb_en_out, hz1, hz2;
    logic [1:0]     count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [RAW-1:0] d;
        logic [N-1:0]   v;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    wb_stage_buffered #(.N(N), .REG_AW(RAW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_res      (alu_res),
        .mem_data     (mem_data),
        .mem_r_en     (mem_r_en),
        .wb_en_in     (wb_en_in),
        .wb_dest_in   (wb_dest_in),
        .ld_size      (ld_size),
        .ld_signed    (ld_signed),
        .addr_lo      (addr_lo),
        .rf_grant     (rf_grant),
        .wb_en_out    (wb_en_out),
        .wb_dest_out  (wb_dest_out),
        .wb_value_out (wb_value_out),
        .hz_src1      (hz_src1),
        .hz_src2      (hz_src2),
        .hz1          (hz1),
        .hz2          (hz2),
        .fwd1         (fwd1),
        .fwd2         (fwd2),
        .count        (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value the current inputs should produce, derived with plain shifts and two's-complement arithmetic.
    function automatic logic [N-1:0] ref_val();
        logic [31:0] x;
        if (!mem_r_en) return alu_res;
        if (ld_size == 2'd0) begin
            x = (mem_data >> (8 * int'(addr_lo))) & 32'hFF;
            if (ld_signed && x >= 32'd128) x = x - 32'd256;
        end else if (ld_size == 2'd1) begin
            x = (mem_data >> (16 * int'(addr_lo[1]))) & 32'hFFFF;
            if (ld_signed && x >= 32'd32768) x = x - 32'd65536;
        end else begin
            x = mem_data;
        end
        return x;
    endfunction

    task automatic idle();
        in_valid   = 1'b0;
        wb_en_in   = 1'b0;
        wb_dest_in = '0;
        alu_res    = '0;
        mem_data   = '0;
        mem_r_en   = 1'b0;
        ld_size    = 2'd0;
        ld_signed  = 1'b0;
        addr_lo    = 2'd0;
        rf_grant   = 1'b0;
        hz_src1    = '0;
        hz_src2    = '0;
    endtask

    // Inputs are already driven (at a negedge); check all outputs, then step the model across the posedge.
    task automatic cycle();
        logic           acc, pop, h1, h2;
        logic [N-1:0]   f1, f2;
        #1;
        acc = in_valid && (q.size() < DEPTH) && wb_en_in;
        pop = (q.size() > 0) && rf_grant;
        h1 = 1'b0; h2 = 1'b0; f1 = '0; f2 = '0;
        if (acc && wb_dest_in == hz_src1) begin h1 = 1'b1; f1 = ref_val(); end
        if (acc && wb_dest_in == hz_src2) begin h2 = 1'b1; f2 = ref_val(); end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!h1 && q[i].d == hz_src1) begin h1 = 1'b1; f1 = q[i].v; end
            if (!h2 && q[i].d == hz_src2) begin h2 = 1'b1; f2 = q[i].v; end
        end
        check("in_ready", in_ready, q.size() < DEPTH);
        check("count", count, q.size());
        check("wb_en_out", wb_en_out, pop);
        check("wb_dest_out", wb_dest_out, q.size() > 0 ? q[0].d : '0);
        check("wb_value_out", wb_value_out, q.size() > 0 ? q[0].v : '0);
        check("hz1", hz1, h1);
        check("hz2", hz2, h2);
        check("fwd1", fwd1, f1);
        check("fwd2", fwd2, f2);
        if (acc) q.push_back('{d: wb_dest_in, v: ref_val()});
        @(posedge clk);
        if (pop) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic push_alu(input logic [RAW-1:0] d, input logic [N-1:0] v, input logic g);
        idle();
        in_valid   = 1'b1;
        wb_en_in   = 1'b1;
        wb_dest_in = d;
        alu_res    = v;
        rf_grant   = g;
        cycle();
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [1:0] lo, input logic [31:0] exp);
        idle();
        in_valid   = 1'b1;
        wb_en_in   = 1'b1;
        wb_dest_in = 4'd9;
        mem_data   = 32'h80FF_7F01;
        mem_r_en   = 1'b1;
        ld_size    = sz;
        ld_signed  = sg;
        addr_lo    = lo;
        cycle();
        idle();
        #1 check(tag, wb_value_out, exp);
        rf_grant = 1'b1;
        cycle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_count", count, 2'd0);
        check("rst_wb_en", wb_en_out, 1'b0);
        check("rst_value", wb_value_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ALU path with immediate grant
        push_alu(4'd3, 32'h1234_5678, 1'b1);
        idle();
        rf_grant = 1'b1;
        #1;
        check("alu_wb_en", wb_en_out, 1'b1);
        check("alu_dest", wb_dest_out, 4'd3);
        check("alu_value", wb_value_out, 32'h1234_5678);
        cycle();
        cycle();

        load_chk("ld_byte_s2", 2'b00, 1'b1, 2'd2, 32'hFFFF_FFFF);
        load_chk("ld_byte_u3", 2'b00, 1'b0, 2'd3, 32'h0000_0080);
        load_chk("ld_half_s2", 2'b01, 1'b1, 2'd2, 32'hFFFF_80FF);
        load_chk("ld_half_u1", 2'b01, 1'b0, 2'd1, 32'h0000_7F01);
        load_chk("ld_word", 2'b10, 1'b1, 2'd3, 32'h80FF_7F01);

        // Back-pressure: fill, refuse a third beat, then drain in order
        push_alu(4'd1, 32'h11, 1'b0);
        push_alu(4'd2, 32'h22, 1'b0);
        idle();
        in_valid = 1'b1; wb_en_in = 1'b1; wb_dest_in = 4'd7;
        #1 check("full_ready", in_ready, 1'b0);
        check("full_count", count, 2'd2);
        cycle();
        idle();
        rf_grant = 1'b1;
        #1 check("drain_first", wb_dest_out, 4'd1);
        cycle();
        check("ready_after_pop", in_ready, 1'b1);
        check("drain_second", wb_dest_out, 4'd2);
        cycle();
        cycle();

        // Youngest-match forwarding
        push_alu(4'd5, 32'hA, 1'b0);
        push_alu(4'd5, 32'hB, 1'b0);
        idle();
        hz_src1 = 4'd5; hz_src2 = 4'd6;
        #1 check("hz_fwd1", fwd1, 32'hB);
        check("hz_hz1", hz1, 1'b1);
        check("hz_hz2", hz2, 1'b0);
        rf_grant = 1'b1;
        cycle();
        cycle();

        // Dropped beats never enqueue
        for (int i = 0; i < 3; i++) begin
            idle();
            in_valid = 1'b1; wb_dest_in = 4'd4; rf_grant = 1'b1; hz_src1 = 4'd4;
            cycle();
        end

        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            wb_en_in   = ($urandom_range(0, 4) != 0);
            wb_dest_in = 4'($urandom_range(0, 7));
            alu_res    = $urandom;
            mem_data   = $urandom;
            mem_r_en   = 1'($urandom_range(0, 1));
            ld_size    = 2'($urandom_range(0, 3));
            ld_signed  = 1'($urandom_range(0, 1));
            addr_lo    = 2'($urandom_range(0, 3));
            rf_grant   = ($urandom_range(0, 2) != 0);
            hz_src1    = 4'($urandom_range(0, 7));
            hz_src2    = 4'($urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset with two writes queued
        idle();
        cycle();
        cycle();
        push_alu(4'd1, 32'h55, 1'b0);
        push_alu(4'd2, 32'h66, 1'b0);
        idle();
        rf_grant = 1'b1; hz_src1 = 4'd1; hz_src2 = 4'd2;
        in_valid = 1'b1; wb_en_in = 1'b1; wb_dest_in = 4'd1;
        #2 rst = 1'b0;
        #1;
        check("arst_count", count, 2'd0);
        check("arst_wb_en", wb_en_out, 1'b0);
        check("arst_hz1", hz1, 1'b0);
        check("arst_hz2", hz2, 1'b0);
        check("arst_ready", in_ready, 1'b0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        idle();
        push_alu(4'd8, 32'hCAFE, 1'b0);
        idle();
        rf_grant = 1'b1;
        #1 check("restart_value", wb_value_out, 32'hCAFE);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
